// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared state encoding, default width and saturation constants
// for the shared-divider scheduler.
package div_sched_pkg;

  localparam int DEF_DATA_W = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [20:0] Q_MAX = 21'h0FFFFF;
  localparam logic [20:0] Q_MIN = 21'h100000;

  // Saturated quotient returned for x/0, chosen by the sign of the dividend.
  function automatic logic [20:0] sat_quot(input logic neg);
    return neg ? Q_MIN : Q_MAX;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; the search starts just after ptr
// and wraps, so the requester at ptr has the lowest priority.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/div_share_scheduler.sv
// div_share_scheduler: shares one open/finish divider among NUM_REQ requesters.
// Optional macro DIV_ZERO_GUARD_EN: x/0 bypasses the divider with a saturated quotient.
module div_share_scheduler
  import div_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_quotient,
  output logic                      rsp_div0,
  output logic                      div_open,
  output logic [DATA_W-1:0]         div_dividend,
  output logic [DATA_W-1:0]         div_divisor,
  input  logic                      div_finish,
  input  logic [DATA_W-1:0]         div_quotient,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, grant_idx_reg;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [DATA_W-1:0]  dividend_arr [NUM_REQ];
  logic [DATA_W-1:0]  divisor_arr  [NUM_REQ];
  logic [DATA_W-1:0]  sel_dividend, sel_divisor;
  logic               accept, finish, consume;
`ifdef DIV_ZERO_GUARD_EN
  logic               zero_div;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign dividend_arr[gi] = req_dividend[gi*DATA_W +: DATA_W];
    assign divisor_arr[gi]  = req_divisor[gi*DATA_W +: DATA_W];
  end

  assign sel_dividend = dividend_arr[arb_idx];
  assign sel_divisor  = divisor_arr[arb_idx];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    consume    = 1'b0;
`ifdef DIV_ZERO_GUARD_EN
    zero_div   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          accept     = 1'b1;
          state_next = RUN;
`ifdef DIV_ZERO_GUARD_EN
          if (sel_divisor == '0) begin
            zero_div   = 1'b1;
            state_next = RESP;
          end
`endif
        end
      end
      RUN: begin
        if (div_finish) begin
          finish     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        // Only the granted line can retire the response.
        if (rsp_ready[grant_idx_reg]) begin
          consume    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= IDX_W'(NUM_REQ - 1);
      grant_idx_reg <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_div0      <= 1'b0;
      div_open      <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      busy          <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy      <= (state_next != IDLE);
      req_ready <= accept ? arb_grant : '0;
      if (accept) begin
        grant_idx_reg <= arb_idx;
        div_dividend  <= sel_dividend;
        div_divisor   <= sel_divisor;
        div_open      <= 1'b1;
      end
      if (finish) begin
        rsp_quotient <= div_quotient;
        rsp_div0     <= 1'b0;
        div_open     <= 1'b0;
        rsp_valid    <= NUM_REQ'(1) << grant_idx_reg;
      end
      if (consume) begin
        rsp_valid <= '0;
        ptr_reg   <= grant_idx_reg;
      end
`ifdef DIV_ZERO_GUARD_EN
      // Overrides the open set by accept: the divider never sees a zero divisor.
      if (zero_div) begin
        div_open     <= 1'b0;
        rsp_valid    <= arb_grant;
        rsp_quotient <= DATA_W'(sat_quot(sel_dividend[DATA_W-1]));
        rsp_div0     <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_div_share_scheduler.sv
// tb_div_share_scheduler: randomized and directed checks of the shared-divider
// scheduler against a queue-based reference model and a behavioural divider.
module tb_div_share_scheduler;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 21;
`ifdef DIV_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_dividend, req_divisor;
  logic [DW-1:0]   rsp_quotient, div_dividend, div_divisor, div_quotient;
  logic            rsp_div0, div_open, div_finish, busy;

  always #5 clk = ~clk;

  div_share_scheduler #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_quotient (rsp_quotient),
    .rsp_div0     (rsp_div0),
    .div_open     (div_open),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_finish   (div_finish),
    .div_quotient (div_quotient),
    .busy         (busy)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] q;
    logic          d0;
  } exp_t;

  exp_t         sb[$];
  int           grant_log[$];
  int           grant_cnt[N];
  int           pass_cnt  = 0;
  int           total_cnt = 0;
  int           rsp_mode  = 0;
  int           mptr      = N - 1;
  logic [N-1:0] samp_valid = '0;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference result from the requester's own operands.
  function automatic exp_t ref_div(input int id, input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    exp_t e;
    e.idx = id;
    if (b == 0) begin
      e.q  = GUARD ? ((a < 0) ? 21'h100000 : 21'h0FFFFF) : 21'h1FFFFF;
      e.d0 = GUARD;
    end else begin
      e.q  = a / b;
      e.d0 = 1'b0;
    end
    return e;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (((v >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (((v >> i) & 1) != 0) return i;
    return -1;
  endfunction

  function automatic logic signed [DW-1:0] rand_op();
    return DW'($urandom_range(0, 20'hFFFFF)) - DW'(20'h80000);
  endfunction

  function automatic logic signed [DW-1:0] rand_dvs();
    if ($urandom_range(0, 7) == 0) return '0;
    return DW'($urandom_range(0, 2000)) - DW'(1000);
  endfunction

  // Behavioural divider: random latency, finish pulse with quotient; x/0 returns all ones.
  initial begin
    int unsigned cnt;
    bit          active;
    div_finish   = 1'b0;
    div_quotient = '0;
    active       = 1'b0;
    cnt          = 0;
    forever begin
      @(posedge clk);
      #1;
      div_finish = 1'b0;
      if (!(rst_n && div_open)) active = 1'b0;
      else if (!active) begin
        active = 1'b1;
        cnt    = $urandom_range(5, 1);
      end else if (cnt > 1) cnt--;
      else begin
        active       = 1'b0;
        div_finish   = 1'b1;
        div_quotient = (div_divisor == '0) ? '1 : DW'($signed(div_dividend) / $signed(div_divisor));
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rsp_mode == 0) rsp_ready = '1;
    else if (rsp_mode == 1) rsp_ready = N'($urandom);
  end

  always @(posedge clk) samp_valid = req_valid;

  int           mon_exp, mon_got, low_cnt = 0;
  bit           open_seen = 1'b0, prev_open = 1'b0;
  logic [N-1:0] mon_oh;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mptr      = N - 1;
      open_seen = 1'b0;
      prev_open = 1'b0;
      low_cnt   = 0;
    end else begin
      if (req_ready != '0) begin
        mon_exp = rr_pick(samp_valid, mptr);
        mon_got = oh_idx(req_ready);
        mon_oh  = (mon_exp >= 0) ? (N'(1) << mon_exp) : '0;
        check("grant", mon_exp >= 0 && req_ready == mon_oh, req_ready, mon_oh);
        if (mon_got >= 0) begin
          grant_log.push_back(mon_got);
          grant_cnt[mon_got]++;
        end
      end
      if ((rsp_valid & rsp_ready) != '0) begin
        if (sb.size() == 0) check("rsp_unexpected", 1'b0, rsp_valid, 0);
        else begin
          mon_e  = sb.pop_front();
          mon_oh = N'(1) << mon_e.idx;
          check("rsp", rsp_valid == mon_oh && rsp_quotient == mon_e.q && rsp_div0 == mon_e.d0,
                {rsp_valid, rsp_div0, rsp_quotient}, {mon_oh, mon_e.d0, mon_e.q});
          $display("txn req%0d quotient=%06h div0=%0b", mon_e.idx, rsp_quotient, rsp_div0);
          mptr = mon_e.idx;
        end
      end
      if (div_open && !prev_open) begin
        if (open_seen) check("open_gap", low_cnt >= 2, low_cnt, 2);
        open_seen = 1'b1;
      end
      if (div_open) low_cnt = 0;
      else low_cnt++;
      prev_open = div_open;
    end
  end

  task automatic issue(input int id, input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    int n = 0;
    req_dividend[id*DW +: DW] = a;
    req_divisor[id*DW +: DW]  = b;
    req_valid[id[IW-1:0]]     = 1'b1;
    do begin
      step(1);
      n++;
    end while (!req_ready[id[IW-1:0]] && n < 3000);
    req_valid[id[IW-1:0]] = 1'b0;
    if (req_ready[id[IW-1:0]]) sb.push_back(ref_div(id, a, b));
    else check("accept_timeout", 1'b0, id, id);
  endtask

  task automatic run_req(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 3));
      issue(id, rand_op(), rand_dvs());
    end
  endtask

  task automatic wait_rsp(input int id);
    int n = 0;
    while (!rsp_valid[id[IW-1:0]] && n < 200) begin
      step(1);
      n++;
    end
    check("wait_rsp", rsp_valid[id[IW-1:0]], rsp_valid, N'(1) << id);
  endtask

  task automatic wait_grant(input int id);
    int n = 0;
    while (grant_cnt[id] == 0 && n < 200) begin
      step(1);
      n++;
    end
    check("wait_grant", grant_cnt[id] != 0, grant_cnt[id], 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy || req_valid != '0) && n < 3000) begin
      step(1);
      n++;
    end
    check("drain", sb.size() == 0 && !busy, sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    grant_log.delete();
    foreach (grant_cnt[i]) grant_cnt[i] = 0;
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c1;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = '0;
    foreach (grant_cnt[i]) grant_cnt[i] = 0;
    step(3);
    check("reset_ctl", {req_ready, rsp_valid, rsp_div0, div_open, busy} == '0,
          {req_ready, rsp_valid, rsp_div0, div_open, busy}, 0);
    check("reset_data", {rsp_quotient, div_dividend, div_divisor} == '0,
          {rsp_quotient, div_dividend, div_divisor}, 0);
    rst_n = 1'b1;
    step(1);

    // Single request from requester 0.
    issue(0, 1000, 7);
    check("t1_open", div_open && busy && req_ready == 4'b0001, {div_open, busy, req_ready}, 6'b11_0001);
    wait_rsp(0);
    check("t1_quot", rsp_quotient == 21'd142 && !div_open, rsp_quotient, 142);
    drain();
    check("t1_single_grant", grant_cnt[0] == 1, grant_cnt[0], 1);

    // All requesters pending: fair rotation from the reset pointer.
    do_reset();
    fork
      begin
        issue(0, rand_op(), 21'sd3);
        issue(0, rand_op(), -21'sd9);
      end
      issue(1, rand_op(), 21'sd17);
      issue(2, rand_op(), -21'sd5);
      issue(3, rand_op(), 21'sd250);
    join
    drain();
    check("t2_count", grant_log.size() == 5, grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check("t2_order", grant_log[i] == i % 4, grant_log[i], i % 4);

    // Response held while other lines assert rsp_ready; pending req1 waits.
    do_reset();
    rsp_mode  = 2;
    rsp_ready = '0;
    issue(2, -21, 4);
    fork
      issue(1, 100, 10);
    join_none
    rsp_ready = 4'b1011;
    wait_rsp(2);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold", rsp_valid == 4'b0100 && rsp_quotient == 21'h1FFFFB && req_ready == '0,
            {req_ready, rsp_valid, rsp_quotient}, {4'b0000, 4'b0100, 21'h1FFFFB});
      step(1);
    end
    rsp_ready = 4'b0100;
    step(1);
    rsp_mode = 0;
    wait_grant(1);
    drain();

    // Asynchronous reset during RUN.
    do_reset();
    issue(0, 300, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_async_ctl", {req_ready, rsp_valid, rsp_div0, div_open, busy} == '0,
          {req_ready, rsp_valid, rsp_div0, div_open, busy}, 0);
    check("t4_async_data", {rsp_quotient, div_dividend, div_divisor} == '0,
          {rsp_quotient, div_dividend, div_divisor}, 0);
    fork
      issue(3, 77, -7);
    join_none
    step(2);
    grant_log.delete();
    foreach (grant_cnt[i]) grant_cnt[i] = 0;
    rst_n = 1'b1;
    wait_grant(3);
    check("t4_first_grant", grant_log.size() > 0 && grant_log[0] == 3,
          grant_log.size() > 0 ? grant_log[0] : -1, 3);
    drain();

    // Divide by zero: bypassed with saturation under the guard, passed through otherwise.
    issue(1, 5, 0);
    check("t5_bypass", rsp_valid == (GUARD ? 4'b0010 : 4'b0000) && div_open == !GUARD,
          {rsp_valid, div_open}, {(GUARD ? 4'b0010 : 4'b0000), !GUARD});
    drain();
    issue(1, -5, 0);
    drain();

    // One-cycle req_valid pulse while busy is never granted.
    issue(0, 9999, 3);
    c1 = grant_cnt[1];
    req_dividend[1*DW +: DW] = 21'd55;
    req_divisor[1*DW +: DW]  = 21'd5;
    req_valid[1] = 1'b1;
    step(1);
    req_valid[1] = 1'b0;
    drain();
    step(5);
    check("t6_no_grant", grant_cnt[1] == c1 && rsp_valid == '0, grant_cnt[1], c1);

    // Randomized contention with random consumer back-pressure.
    rsp_mode = 1;
    fork
      run_req(0, 10);
      run_req(1, 10);
      run_req(2, 10);
      run_req(3, 10);
    join
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
